// File: rtl/add_seq_nibble.sv
// -----------------------------------------------------------------------------
// add_seq_nibble
//   Adds or subtracts two W-bit operands (W = 4*NIBBLES) using one shared
//   4-bit adder, one nibble per clock, least-significant nibble first.
//   The inter-nibble carry lives in a 1-bit register. The result is reported
//   with a one-cycle done pulse.
//
//   Ports
//     clk    in   system clock, rising edge
//     rst_n  in   asynchronous active-low reset
//     start  in   request; accepted only when idle or in the done cycle
//     sub    in   0 = a+b, 1 = a-b (sampled with start)
//     a, b   in   W-bit operands (sampled with start)
//     busy   out  high while nibbles are being processed
//     done   out  one-cycle pulse; sum/cout/ovf valid from this cycle
//     sum    out  result modulo 2^W
//     cout   out  carry out of MSB (subtract: 1 = no borrow)
//     ovf    out  two's-complement signed overflow
// -----------------------------------------------------------------------------

module ADD_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module add_seq_nibble #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 sub,
   input  logic [4*NIBBLES-1:0] a,
   input  logic [4*NIBBLES-1:0] b,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] sum,
   output logic                 cout,
   output logic                 ovf
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]       state;
   logic [IDX_W-1:0] idx;
   logic             carry;
   logic [W-1:0]     a_q;
   logic [W-1:0]     beff_q;
   logic [W-1:0]     work_q;
   logic [W-1:0]     work_nxt;
   logic [3:0]       nib_a;
   logic [3:0]       nib_b;
   logic [3:0]       add_s;
   logic             add_c;
   logic             accept;

   // Signed overflow: operands agree in sign but the result does not.
   function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

   // A new request is taken in IDLE and also in the DONE cycle, so
   // back-to-back requests need no bubble.
   assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

   assign nib_a = a_q[{idx, 2'b00} +: 4];
   assign nib_b = beff_q[{idx, 2'b00} +: 4];

   ADD_4bit u_add (
      .a    (nib_a),
      .b    (nib_b),
      .cin  (carry),
      .s    (add_s),
      .cout (add_c)
   );

   // Working result with the current nibble merged in; on the last nibble
   // this is the complete result that is loaded into sum.
   always_comb begin
      work_nxt = work_q;
      work_nxt[{idx, 2'b00} +: 4] = add_s;
   end

   // Operand / working-result datapath: no reset needed, contents are only
   // consumed after a request has been accepted.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q    <= a;
         beff_q <= b ^ {W{sub}};
      end
      if (state == ST_RUN) begin
         work_q <= work_nxt;
      end
   end

   // Control and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         idx   <= '0;
         carry <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state <= ST_RUN;
                  busy  <= 1'b1;
                  idx   <= '0;
                  carry <= sub;   // +1 of the two's-complement negate
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               carry <= add_c;
               if (idx == LAST_IDX) begin
                  // Result is loaded on entry to DONE so it is valid
                  // together with the done pulse.
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  sum   <= work_nxt;
                  cout  <= add_c;
                  ovf   <= signed_ovf(a_q[W-1], beff_q[W-1], add_s[3]);
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_add_seq_nibble.sv
// -----------------------------------------------------------------------------
// tb_add_seq_nibble
//   Self-checking bench for add_seq_nibble. Three instances (NIBBLES = 2, 4, 8)
//   each have their own start line and share the operand buses. Expected
//   results come from a plain-arithmetic reference model.
// -----------------------------------------------------------------------------

module tb_add_seq_nibble;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  st;
   logic        sub;
   logic [31:0] a_in, b_in;

   logic        busy2, done2, cout2, ovf2;
   logic [7:0]  sum2;
   logic        busy4, done4, cout4, ovf4;
   logic [15:0] sum4;
   logic        busy8, done8, cout8, ovf8;
   logic [31:0] sum8;

   int checks;
   int errors;

   logic [31:0] last_s [3];
   logic        last_c [3];
   logic        last_o [3];

   always #5 clk = ~clk;

   add_seq_nibble #(.NIBBLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sub),
      .a(a_in[7:0]), .b(b_in[7:0]),
      .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

   add_seq_nibble #(.NIBBLES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sub),
      .a(a_in[15:0]), .b(b_in[15:0]),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4));

   add_seq_nibble #(.NIBBLES(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sub),
      .a(a_in), .b(b_in),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

   function automatic int sel(input int n);
      case (n)
         2:       return 0;
         4:       return 1;
         default: return 2;
      endcase
   endfunction

   // Reference: {ovf, cout, sum} from integer arithmetic on the operands.
   function automatic logic [33:0] model(input int n, input logic [31:0] aa,
                                         input logic [31:0] bb, input logic s);
      longint full, half, ua, ub, sa, sb, r;
      logic [31:0] sm;
      logic c, o;
      full = longint'(1) << (4 * n);
      half = full / 2;
      ua = 0; ua[31:0] = aa; ua = ua % full;
      ub = 0; ub[31:0] = bb; ub = ub % full;
      sa = (ua >= half) ? ua - full : ua;
      sb = (ub >= half) ? ub - full : ub;
      if (s) begin
         r  = sa - sb;
         c  = (ua >= ub);
         sm = 32'((ua - ub + full) % full);
      end else begin
         r  = sa + sb;
         c  = ((ua + ub) >= full);
         sm = 32'((ua + ub) % full);
      end
      o = (r >= half) || (r < -half);
      return {o, c, sm};
   endfunction

   task automatic sample(input int n, output logic d, output logic bz,
                         output logic c, output logic o, output logic [31:0] sm);
      case (n)
         2: begin d = done2; bz = busy2; c = cout2; o = ovf2; sm = {24'd0, sum2}; end
         4: begin d = done4; bz = busy4; c = cout4; o = ovf4; sm = {16'd0, sum4}; end
         default: begin d = done8; bz = busy8; c = cout8; o = ovf8; sm = sum8; end
      endcase
   endtask

   task automatic clear_last();
      for (int i = 0; i < 3; i++) begin
         last_s[i] = '0; last_c[i] = 1'b0; last_o[i] = 1'b0;
      end
   endtask

   // One request on instance n; checks latency, result, and output hold.
   task automatic do_op(input int n, input logic [31:0] aa, input logic [31:0] bb,
                        input logic s, input string tag);
      logic [33:0] e;
      logic d, bz, c, o;
      logic [31:0] sm;
      int k;
      bit seen;
      k = sel(n);
      seen = 0;
      e = model(n, aa, bb, s);
      @(negedge clk);
      a_in = aa; b_in = bb; sub = s; st[k] = 1'b1;
      @(posedge clk);
      #1 st[k] = 1'b0;
      for (int cyc = 1; cyc <= n + 6 && !seen; cyc++) begin
         @(negedge clk);
         sample(n, d, bz, c, o, sm);
         checks++;
         if (d && bz) begin
            errors++;
            $display("FAIL %s busy_and_done cyc=%0d got busy=%b done=%b want not both", tag, cyc, bz, d);
         end
         if (d) begin
            seen = 1;
            checks++;
            if (cyc != n + 1) begin
               errors++;
               $display("FAIL %s latency got %0d want %0d", tag, cyc, n + 1);
            end
            checks++;
            if (sm !== e[31:0]) begin
               errors++;
               $display("FAIL %s sum got %h want %h", tag, sm, e[31:0]);
            end
            checks++;
            if (c !== e[32]) begin
               errors++;
               $display("FAIL %s cout got %b want %b", tag, c, e[32]);
            end
            checks++;
            if (o !== e[33]) begin
               errors++;
               $display("FAIL %s ovf got %b want %b", tag, o, e[33]);
            end
            last_s[k] = e[31:0]; last_c[k] = e[32]; last_o[k] = e[33];
         end else if (cyc == 2) begin
            checks++;
            if (sm !== last_s[k] || c !== last_c[k] || o !== last_o[k]) begin
               errors++;
               $display("FAIL %s hold got %h/%b/%b want %h/%b/%b", tag, sm, c, o,
                        last_s[k], last_c[k], last_o[k]);
            end
            checks++;
            if (bz !== 1'b1) begin
               errors++;
               $display("FAIL %s busy got %b want 1", tag, bz);
            end
         end
      end
      if (!seen) begin
         errors++;
         $display("FAIL %s done_timeout got no done want done", tag);
      end
   endtask

   task automatic test_reset();
      logic d, bz, c, o;
      logic [31:0] sm;
      rst_n = 1'b0; st = '0; sub = 1'b0; a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sample(2 << i, d, bz, c, o, sm);
         checks++;
         if ({d, bz, c, o} !== 4'b0000 || sm !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs n=%0d got d=%b b=%b c=%b o=%b s=%h want all 0",
                     2 << i, d, bz, c, o, sm);
         end
      end
      rst_n = 1'b1;
      clear_last();
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b done=%b want 0/0", busy4, done4);
         end
      end
   endtask

   task automatic test_add();
      do_op(4, 32'h1234, 32'h4321, 1'b0, "add_basic");
      do_op(4, 32'hFFFF, 32'h0001, 1'b0, "add_carry");
      do_op(4, 32'h7FFF, 32'h0001, 1'b0, "add_ovf");
      for (int i = 0; i < 4; i++)
         do_op(4, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 1'b0, "add_rand");
   endtask

   task automatic test_sub();
      do_op(4, 32'h0005, 32'h0007, 1'b1, "sub_borrow");
      do_op(4, 32'h8000, 32'h0001, 1'b1, "sub_ovf");
      for (int i = 0; i < 4; i++)
         do_op(4, $urandom & 32'hFFFF, $urandom & 32'hFFFF, 1'b1, "sub_rand");
   endtask

   task automatic test_busy_protect();
      int ndone;
      ndone = 0;
      @(negedge clk);
      a_in = 32'h0001; b_in = 32'h0001; sub = 1'b0; st[1] = 1'b1;
      @(posedge clk);
      #1 st[1] = 1'b0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
         @(negedge clk);
         if (cyc == 2) begin a_in = 32'hAAAA; st[1] = 1'b1; end
         if (cyc == 3) st[1] = 1'b0;
         if (done4) begin
            ndone++;
            checks++;
            if (cyc != 5 || sum4 !== 16'h0002) begin
               errors++;
               $display("FAIL busy_protect_result got cyc=%0d sum=%h want cyc=5 sum=0002", cyc, sum4);
            end
         end
      end
      checks++;
      if (ndone != 1) begin
         errors++;
         $display("FAIL busy_protect_count got %0d dones want 1", ndone);
      end
      last_s[1] = 32'h0002; last_c[1] = 1'b0; last_o[1] = 1'b0;
   endtask

   task automatic test_back_to_back();
      localparam int K = 6;
      logic [33:0] expq[$];
      logic [33:0] e;
      logic [15:0] ra, rb;
      logic rs;
      @(negedge clk);
      for (int t = 0; t <= 5 * K; t++) begin
         if (t > 0) @(negedge clk);
         if (t % 5 == 0) begin
            if (t > 0) begin
               e = expq.pop_front();
               checks++;
               if (done4 !== 1'b1 || busy4 !== 1'b0) begin
                  errors++;
                  $display("FAIL b2b_done t=%0d got done=%b busy=%b want 1/0", t, done4, busy4);
               end
               checks++;
               if (sum4 !== e[15:0] || cout4 !== e[32] || ovf4 !== e[33]) begin
                  errors++;
                  $display("FAIL b2b_result t=%0d got %h/%b/%b want %h/%b/%b", t,
                           sum4, cout4, ovf4, e[15:0], e[32], e[33]);
               end
               last_s[1] = {16'd0, e[15:0]}; last_c[1] = e[32]; last_o[1] = e[33];
            end
            if (t < 5 * K) begin
               ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
               expq.push_back(model(4, {16'd0, ra}, {16'd0, rb}, rs));
               a_in = {16'd0, ra}; b_in = {16'd0, rb}; sub = rs; st[1] = 1'b1;
            end else begin
               st[1] = 1'b0;
            end
         end else begin
            checks++;
            if (done4 !== 1'b0 || busy4 !== 1'b1 || sum4 !== last_s[1][15:0] ||
                cout4 !== last_c[1] || ovf4 !== last_o[1]) begin
               errors++;
               $display("FAIL b2b_between t=%0d got d=%b b=%b s=%h want d=0 b=1 s=%h",
                        t, done4, busy4, sum4, last_s[1][15:0]);
            end
            // Operands change while running; they must not disturb the result.
            a_in = $urandom; b_in = $urandom; sub = 1'($urandom);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      do_op(4, 32'h1111, 32'h2222, 1'b0, "pre_reset");
      @(negedge clk);
      a_in = 32'h4444; b_in = 32'h1234; sub = 1'b0; st[1] = 1'b1;
      @(posedge clk);
      #1 st[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (sum4 !== 16'd0 || cout4 !== 1'b0 || ovf4 !== 1'b0 || busy4 !== 1'b0 || done4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_outputs got s=%h c=%b o=%b b=%b d=%b want all 0",
                  sum4, cout4, ovf4, busy4, done4);
      end
      clear_last();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_nodone got done=%b busy=%b want 0/0", done4, busy4);
         end
      end
      do_op(4, 32'h0F0F, 32'h00F1, 1'b0, "post_reset");
   endtask

   task automatic test_width();
      do_op(2, 32'h12, 32'h21, 1'b0, "n2_add");
      do_op(2, 32'hFF, 32'h01, 1'b0, "n2_carry");
      do_op(2, 32'h7F, 32'h01, 1'b0, "n2_ovf");
      do_op(2, $urandom & 32'hFF, $urandom & 32'hFF, 1'b1, "n2_rand_sub");
      do_op(8, 32'h12345678, 32'h87654321, 1'b0, "n8_add");
      do_op(8, 32'hFFFFFFFF, 32'h00000001, 1'b0, "n8_carry");
      do_op(8, 32'h7FFFFFFF, 32'h00000001, 1'b0, "n8_ovf");
      do_op(8, $urandom, $urandom, 1'b1, "n8_rand_sub");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_last();
      test_reset();
      test_add();
      test_sub();
      test_busy_protect();
      test_back_to_back();
      test_reset_mid();
      test_width();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
